ped_button_conditioner: RTL and testbench

Upstream stage of trafficlight; converts the raw asynchronous pedestrian push-button into the single-cycle pdst request pulse that trafficlight consumes. Synchronises and debounces the button, then emits one pulse per accepted press. Holds a pending flag until trafficlight shows red, then enforces a cooldown so repeated presses cannot flood the controller.

---
 rtl/ped_button_conditioner.sv | 134 +++++++++++++
 tb/tb_ped_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button conditioner.
// Synchronises and debounces the raw button and turns each accepted press into
// a one-cycle pdst pulse. The request then stays pending until the light shows
// red, and a cooldown window follows during which further presses are ignored.
//
// state    | meaning
// IDLE     | waiting for a debounced press
// PENDING  | request issued, waiting for red on the light
// COOLDOWN | request served, presses ignored until the counter expires
module ped_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [2:0] light,
    output logic       pdst,
    output logic       req_pending,
    output logic       cooldown
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [2:0]       LIGHT_RED = 3'b100;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_state_q, db_state_d;
    logic             db_prev_q, db_prev_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
    state_t           state_q, state_d;
    logic             pdst_q, pdst_d;
    logic             req_pending_q, req_pending_d;
    logic             cooldown_q, cooldown_d;
    logic             press;

    // Two-flop synchroniser and debounce: state flips only after s2 has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        s1_d       = btn_raw;
        s2_d       = s1_q;
        db_prev_d  = db_state_q;
        db_state_d = db_state_q;
        db_cnt_d   = '0;
        if (s2_q != db_state_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_state_d = s2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Only the rising edge of the debounced state is a press.
    assign press = db_state_q & ~db_prev_q;

    // Request FSM next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        pdst_d   = 1'b0;
        cd_cnt_d = cd_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PENDING;
                    pdst_d  = 1'b1;
                end
            end
            PENDING: begin
                // Red is only honoured after the pulse cycle itself.
                if (!pdst_q && (light == LIGHT_RED)) begin
                    state_d  = COOLDOWN;
                    cd_cnt_d = '0;
                end
            end
            COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    state_d  = IDLE;
                    cd_cnt_d = '0;
                end else begin
                    cd_cnt_d = cd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cd_cnt_d = '0;
            end
        endcase
        req_pending_d = (state_d == PENDING);
        cooldown_d    = (state_d == COOLDOWN);
    end

    // All state registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            db_state_q    <= 1'b0;
            db_prev_q     <= 1'b0;
            db_cnt_q      <= '0;
            cd_cnt_q      <= '0;
            state_q       <= IDLE;
            pdst_q        <= 1'b0;
            req_pending_q <= 1'b0;
            cooldown_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            db_state_q    <= db_state_d;
            db_prev_q     <= db_prev_d;
            db_cnt_q      <= db_cnt_d;
            cd_cnt_q      <= cd_cnt_d;
            state_q       <= state_d;
            pdst_q        <= pdst_d;
            req_pending_q <= req_pending_d;
            cooldown_q    <= cooldown_d;
        end
    end

    assign pdst        = pdst_q;
    assign req_pending = req_pending_q;
    assign cooldown    = cooldown_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Testbench for ped_button_conditioner: directed stimulus pushes expected
// output transitions {cycle, {pdst,req_pending,cooldown}} into a queue; a
// monitor compares every observed output change against the queue head.
module tb_ped_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [2:0] light;
    logic       pdst;
    logic       req_pending;
    logic       cooldown;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc     = 0;
    int         n_total = 0;
    int         n_pass  = 0;
    logic       mon_en  = 1'b0;
    logic [2:0] prev_vec = 3'b000;

    ped_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(16),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .light(light),
        .pdst(pdst),
        .req_pending(req_pending),
        .cooldown(cooldown)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [2:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: invariants every cycle, and every output change must match
    // the next expected transition in cycle and value.
    always @(negedge clk) begin
        logic [2:0] vec;
        ev_t        e;
        if (mon_en) begin
            vec = {pdst, req_pending, cooldown};
            check("pdst_implies_req", int'(pdst & ~req_pending), 0);
            check("cd_req_exclusive", int'(cooldown & req_pending), 0);
            if (vec != prev_vec) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_change: cycle %0d got %b, expected no change",
                             cyc, vec);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_value", int'(vec), int'(e.vec));
                end
                prev_vec = vec;
            end
        end
    end

    initial begin
        int k;
        rst     = 1'b1;
        btn_raw = 1'b0;
        light   = 3'b001;
        tick(2);
        check("reset_outputs", int'({pdst, req_pending, cooldown}), 0);
        mon_en = 1'b1;
        rst    = 1'b0;
        tick(2);

        // Clean press, held 20 cycles: one pulse at +7, then pending.
        k = cyc;
        btn_raw = 1'b1;
        expect_ev(k + 7, 3'b110);
        expect_ev(k + 8, 3'b010);
        tick(20);
        btn_raw = 1'b0;
        tick(8);

        // Second press while pending: ignored.
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(8);

        // Service: red -> cooldown next cycle, 16 cycles, a press inside ignored.
        k = cyc;
        light = 3'b100;
        expect_ev(k + 1, 3'b001);
        expect_ev(k + 17, 3'b000);
        tick(2);
        light   = 3'b001;
        btn_raw = 1'b1;
        tick(8);
        btn_raw = 1'b0;
        tick(10);

        // Press after cooldown ended: new pulse.
        k = cyc;
        btn_raw = 1'b1;
        expect_ev(k + 7, 3'b110);
        expect_ev(k + 8, 3'b010);
        tick(10);
        btn_raw = 1'b0;
        tick(8);

        // Press event lands on the cooldown expiry cycle: dropped.
        k = cyc;
        light = 3'b100;
        expect_ev(k + 1, 3'b001);
        expect_ev(k + 17, 3'b000);
        tick(1);
        light = 3'b001;
        tick(9);
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(8);

        // Press while light already red: pulse, then cooldown after it.
        k = cyc;
        light   = 3'b100;
        btn_raw = 1'b1;
        expect_ev(k + 7, 3'b110);
        expect_ev(k + 8, 3'b010);
        expect_ev(k + 9, 3'b001);
        expect_ev(k + 25, 3'b000);
        tick(10);
        btn_raw = 1'b0;
        light   = 3'b001;
        tick(20);

        // Reset during PENDING with button held: cleared, then fresh pulse.
        k = cyc;
        btn_raw = 1'b1;
        expect_ev(k + 7, 3'b110);
        expect_ev(k + 8, 3'b010);
        tick(10);
        rst = 1'b1;
        expect_ev(k + 11, 3'b000);
        tick(2);
        rst = 1'b0;
        expect_ev(k + 19, 3'b110);
        expect_ev(k + 20, 3'b010);
        tick(10);

        // Clear back to IDLE.
        k = cyc;
        rst     = 1'b1;
        btn_raw = 1'b0;
        expect_ev(k + 1, 3'b000);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Bounce: 2 high / 1 low x5, then steady high -> one pulse.
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            tick(2);
            btn_raw = 1'b0;
            tick(1);
        end
        k = cyc;
        btn_raw = 1'b1;
        expect_ev(k + 7, 3'b110);
        expect_ev(k + 8, 3'b010);
        tick(12);

        // Clear again, then a lone 3-cycle glitch must not pulse.
        k = cyc;
        rst     = 1'b1;
        btn_raw = 1'b0;
        expect_ev(k + 1, 3'b000);
        tick(2);
        rst = 1'b0;
        tick(3);
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(15);

        check("pending_expected_events", exp_q.size(), 0);
        check("final_outputs", int'({pdst, req_pending, cooldown}), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
